// File: rtl/rs_latch_bank_ctrl.sv
// Round-robin sequencer sharing a bank of enable-gated RS latches between requesters.
// Each granted request runs set-up, enable pulse and a Q read-back check.
module rs_latch_bank_ctrl #(
    parameter int NREQ      = 4,
    parameter int NLATCH    = 8,
    parameter int ADDR_W    = 3,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          op_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          done_o,
    output logic [NLATCH-1:0]        ls_o,
    output logic [NLATCH-1:0]        lr_o,
    output logic [NLATCH-1:0]        le_o,
    input  logic [NLATCH-1:0]        q_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              op_q, op_d;
    logic [NLATCH-1:0] sel_q, sel_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NLATCH-1:0] ls_q, ls_d, lr_q, lr_d, le_q, le_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              win_vld;
    logic [PTR_W-1:0]  win_idx, scan_idx;
    logic              cap_op;
    logic [ADDR_W-1:0] cap_addr;
    logic [NLATCH-1:0] cap_sel;
    logic              q_bit;

    // Scan starts just after the last winner, so a persistent requester yields.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = PTR_W'((int'(ptr_q) + i) % NREQ);
            if (!win_vld && req_i[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // An out-of-range address yields an empty select, so no latch line is ever driven.
    always_comb begin
        cap_op   = 1'b0;
        cap_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                cap_op   = op_i[i];
                cap_addr = addr_i[i*ADDR_W +: ADDR_W];
            end
        end
        cap_sel = (int'(cap_addr) < NLATCH) ? (NLATCH'(1) << cap_addr) : '0;
    end

    assign q_bit = |(q_i & sel_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ls_d    = ls_q;
        lr_d    = lr_q;
        le_d    = le_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    ptr_d   = win_idx;
                    op_d    = cap_op;
                    sel_d   = cap_sel;
                    gnt_d   = NREQ'(1) << win_idx;
                    ls_d    = cap_op ? cap_sel : '0;
                    lr_d    = cap_op ? '0 : cap_sel;
                    le_d    = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    le_d    = sel_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                    le_d    = '0;
                    ls_d    = '0;
                    lr_d    = '0;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                if (!(|sel_q) || (q_bit != op_q))
                    err_d = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_W'(NREQ - 1);
            op_q    <= 1'b0;
            sel_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ls_q    <= '0;
            lr_q    <= '0;
            le_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ls_q    <= ls_d;
            lr_q    <= lr_d;
            le_q    <= le_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign ls_o   = ls_q;
    assign lr_o   = lr_q;
    assign le_o   = le_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_rs_latch_bank_ctrl.sv
// Bench for rs_latch_bank_ctrl: a driver predicts each transaction and queues it,
// a monitor checks the DUT cycle by cycle against the queued expectation.
module tb_rs_latch_bank_ctrl;
    localparam int NREQ = 4;
    localparam int NL   = 6;
    localparam int AW   = 3;
    localparam int AWT  = NREQ * AW;
    localparam int SC   = 1;
    localparam int PC   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req, op, gnt, done;
    logic [AWT-1:0]  addr;
    logic [NL-1:0]   ls, lr, le, q, stuck;
    logic [NL-1:0]   q_lat = '0;
    logic            busy, err;

    int checks   = 0;
    int failures = 0;
    int ptr_m;
    logic err_m;

    typedef struct {
        int   w;
        logic op;
        int   a;
        logic err;
        logic q;
        int   abort_k;
    } exp_t;
    exp_t sbq[$];

    rs_latch_bank_ctrl #(
        .NREQ(NREQ), .NLATCH(NL), .ADDR_W(AW), .SETUP_CYC(SC), .PULSE_CYC(PC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .addr_i(addr),
        .gnt_o(gnt), .done_o(done), .ls_o(ls), .lr_o(lr), .le_o(le),
        .q_i(q), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // Behavioural latch bank; a stuck bit reads back 0 regardless of content.
    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (le[k]) begin
                if (ls[k]) q_lat[k] <= 1'b1;
                else if (lr[k]) q_lat[k] <= 1'b0;
            end
        end
    end
    assign q = q_lat & ~stuck;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 1; i <= NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    always @(negedge clk)
        chk("latch_invariants",
            64'({($countones(le) > 1), |(ls & lr), |(le & ~(ls ^ lr))}), 64'(0));

    task automatic run_txn(input exp_t e);
        logic [NREQ-1:0] g;
        logic [NL-1:0]   sel, s_exp, r_exp;
        g     = NREQ'(1) << e.w;
        sel   = (e.a < NL) ? (NL'(1) << e.a) : '0;
        s_exp = e.op ? sel : '0;
        r_exp = e.op ? '0 : sel;
        for (int k = 1; k <= SC + PC + 2; k++) begin
            if (k > 1) @(negedge clk);
            if (k == e.abort_k) begin
                chk("reset_midpulse", 64'({gnt, done, ls, lr, le, busy, err}), 64'(0));
                return;
            end
            if (k <= SC)
                chk("setup", 64'({gnt, done, ls, lr, le, busy}),
                    64'({g, NREQ'(0), s_exp, r_exp, NL'(0), 1'b1}));
            else if (k <= SC + PC)
                chk("pulse", 64'({gnt, done, ls, lr, le, busy}),
                    64'({g, NREQ'(0), s_exp, r_exp, sel, 1'b1}));
            else if (k == SC + PC + 1)
                chk("check_done", 64'({gnt, done, ls, lr, le, busy}),
                    64'({g, g, NL'(0), NL'(0), NL'(0), 1'b1}));
            else begin
                chk("idle_after", 64'({gnt, done, busy, err}),
                    64'({NREQ'(0), NREQ'(0), 1'b0, e.err}));
                if (e.a < NL) chk("latch_q", 64'(q[e.a]), 64'(e.q));
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt !== '0) begin
                if (sbq.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'(0));
                else begin
                    e = sbq.pop_front();
                    run_txn(e);
                end
            end
        end
    end

    // Called on the falling edge of an idle cycle; returns on the next idle one.
    task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ-1:0] o,
                          input logic [AWT-1:0] ad, input bit hold, input bit abort);
        exp_t e;
        int   w;
        w      = pick(r, ptr_m);
        ptr_m  = w;
        e.w    = w;
        e.op   = o[w];
        e.a    = int'(ad[w*AW +: AW]);
        e.abort_k = abort ? 3 : 0;
        e.q    = (e.a < NL) ? (e.op & ~stuck[e.a]) : 1'b0;
        if (!abort && (e.a >= NL || e.q != e.op)) err_m = 1'b1;
        e.err  = err_m;
        sbq.push_back(e);
        req = r; op = o; addr = ad;
        @(negedge clk);
        op   = NREQ'($urandom);
        addr = AWT'($urandom);
        if (!hold) req = NREQ'($urandom);
        if (abort) begin
            @(negedge clk);
            rst = 1'b1; req = '0;
            @(negedge clk);
            rst = 1'b0; ptr_m = NREQ - 1; err_m = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic sys_reset();
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0; ptr_m = NREQ - 1; err_m = 1'b0;
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_txn(input bit hold);
        do_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), NREQ'($urandom),
               AWT'($urandom), hold, 1'b0);
    endtask

    initial begin
        logic [AWT-1:0] ad;
        rst = 1'b1; req = '0; op = '0; addr = '0; stuck = '0;
        ptr_m = NREQ - 1; err_m = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({gnt, done, ls, lr, le, busy, err}), 64'(0));
        rst = 1'b0;

        ad = AWT'($urandom); ad[0*AW +: AW] = AW'(5);
        do_txn(4'b0001, 4'b0001, ad, 1'b0, 1'b0);
        ad = AWT'($urandom); ad[2*AW +: AW] = AW'(5);
        do_txn(4'b0100, 4'b0000, ad, 1'b0, 1'b0);

        sys_reset();
        repeat (5) do_txn(4'b1111, NREQ'($urandom), AWT'($urandom), 1'b1, 1'b0);
        idle(2);

        stuck = NL'(1) << 3;
        ad = AWT'($urandom); ad[2*AW +: AW] = AW'(3);
        do_txn(4'b0100, 4'b1111, ad, 1'b0, 1'b0);
        repeat (10) rand_txn(1'b0);
        stuck = '0;

        sys_reset();
        ad = AWT'($urandom); ad[1*AW +: AW] = AW'(7);
        do_txn(4'b0010, NREQ'($urandom), ad, 1'b0, 1'b0);

        sys_reset();
        ad = AWT'($urandom); ad[0*AW +: AW] = AW'(2);
        do_txn(4'b0001, 4'b0001, ad, 1'b0, 1'b1);
        do_txn(4'b0010, NREQ'($urandom), AWT'($urandom), 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 19) == 0) sys_reset();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            rand_txn(1'($urandom));
        end

        idle(8);
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
